// File: rtl/jcsa_serial_wide_adder.sv
// Multi-cycle WIDTH-bit adder that streams one 8-bit slice per clock through a
// single 8-bit carry-skip adder, carrying between slices in a register.
// Optional feature macro: JCSA_SERIAL_SUB_EN adds a 'sub' input that turns the
// operation into A - B (B inverted, initial carry forced to 1).

module jcsa_serial_wide_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carryin,
`ifdef JCSA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carryout,
    output logic             overflow
);

    localparam int unsigned NSLICE = WIDTH / 8;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx;

    logic [IDX_W+2:0] bit_lo;
    logic [7:0]       slice_a;
    logic [7:0]       slice_b;
    logic [7:0]       slice_sum;
    logic             slice_co;
    logic             last_slice;
    logic [WIDTH-1:0] b_in;
    logic             carry_in0;

    // Operand preparation at accept: optional inversion for subtraction
`ifdef JCSA_SERIAL_SUB_EN
    assign b_in      = sub ? ~B : B;
    assign carry_in0 = sub ? 1'b1 : carryin;
`else
    assign b_in      = B;
    assign carry_in0 = carryin;
`endif

    // Select the current 8-bit slice of the latched operands
    assign bit_lo     = {idx, 3'b000};
    assign slice_a    = a_r[bit_lo +: 8];
    assign slice_b    = b_r[bit_lo +: 8];
    assign last_slice = (idx == IDX_W'(NSLICE - 1));

    jcarryskipadder u_adder (
        .A        (slice_a),
        .B        (slice_b),
        .carryin  (carry_r),
        .Y        (slice_sum),
        .carryout (slice_co)
    );

    // Control FSM, operand latches and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
            Y         <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= b_in;
                        carry_r  <= carry_in0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Y[bit_lo +: 8] <= slice_sum;
                    carry_r        <= slice_co;
                    idx            <= idx + IDX_W'(1);
                    if (last_slice) begin
                        carryout  <= slice_co;
                        // Final MSB comes straight from this slice's sum
                        overflow  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (slice_sum[7] != a_r[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// 8-bit carry-skip adder: two 4-bit ripple blocks, each bypassed when every
// bit in the block propagates.
module jcarryskipadder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       carryin,
    output logic [7:0] Y,
    output logic       carryout
);

    logic [7:0] p;
    logic [7:0] g;

    assign p = A ^ B;
    assign g = A & B;

    // Ripple within each block; skip the block carry when it fully propagates
    always_comb begin
        logic c;
        logic rc;
        c  = carryin;
        rc = 1'b0;
        Y  = '0;
        for (int blk = 0; blk < 2; blk++) begin
            rc = c;
            for (int i = 0; i < 4; i++) begin
                Y[4*blk+i] = p[4*blk+i] ^ rc;
                rc         = g[4*blk+i] | (p[4*blk+i] & rc);
            end
            c = (&p[4*blk +: 4]) ? c : rc;
        end
        carryout = c;
    end

endmodule
